// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and state encoding for the FIFO word packer.
// HEADER_BYTES is the block-header size the packer is normally built for.
package fifo_word_packer_pkg;

   localparam int HEADER_BYTES           = 80;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO read port and the packed-word valid/ready output.
// The master modport is the packer; the slave modport is the surrounding FIFO and consumer.
interface fifo_word_packer_if
   import fifo_word_packer_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int BYTES_PER_WORD = HEADER_BYTES,
   parameter int CNT_WIDTH      = 7
);
   logic                                 fifo_empty;
   logic                                 fifo_re;
   logic [DATA_WIDTH-1:0]                fifo_data;
   logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_data;
   logic                                 word_valid;
   logic                                 word_ready;
   logic [CNT_WIDTH-1:0]                 fill_level;
   logic                                 drop_pulse;

   modport master (
      input  fifo_empty, fifo_data, word_ready,
      output fifo_re, word_data, word_valid, fill_level, drop_pulse
   );

   modport slave (
      output fifo_empty, fifo_data, word_ready,
      input  fifo_re, word_data, word_valid, fill_level, drop_pulse
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops BYTES_PER_WORD FIFO entries and packs them MSB-first into one word on a valid/ready output.
// Define PACKER_TIMEOUT_EN to discard a partial word after TIMEOUT_CYCLES idle cycles.
module fifo_word_packer
   import fifo_word_packer_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int BYTES_PER_WORD = HEADER_BYTES,
   parameter int CNT_WIDTH      = 7,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input logic                clk,
   input logic                rst,
   fifo_word_packer_if.master bus
);
   localparam int                   W    = DATA_WIDTH * BYTES_PER_WORD;
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(BYTES_PER_WORD);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BYTES_PER_WORD - 1);

   if (BYTES_PER_WORD < 2 || (64'd1 << CNT_WIDTH) <= 64'(BYTES_PER_WORD) || TIMEOUT_CYCLES < 1)
   begin : g_bad_params
      $error("fifo_word_packer: illegal parameter combination");
   end

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d;
   logic [CNT_WIDTH-1:0] fill_q, fill_d;
   logic                 rd_pend_q, rd_pend_d;
   logic                 valid_q, valid_d;
   logic [W-1:0]         word_q, word_d;
   logic                 timeout_hit;
   logic                 pop;

`ifdef PACKER_TIMEOUT_EN
   localparam int                    IDLE_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_WIDTH-1:0] IDLE_LIMIT = IDLE_WIDTH'(TIMEOUT_CYCLES);

   logic [IDLE_WIDTH-1:0] idle_q, idle_d;
   logic                  partial;

   assign partial     = (state_q == ST_FILL) && (fill_q != '0) && (fill_q < FULL);
   assign timeout_hit = partial && !rd_pend_q && (idle_q == IDLE_LIMIT);

   always_comb begin
      idle_d = idle_q;
      if (!partial || rd_pend_q || timeout_hit) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Pop decision uses registered state only, so fifo_data never feeds back into fifo_re.
   assign pop = (state_q == ST_FILL) && !bus.fifo_empty && (req_cnt_q < FULL) && !timeout_hit;

   always_comb begin
      state_d   = state_q;
      req_cnt_d = req_cnt_q;
      rd_pend_d = pop;
      fill_d    = fill_q;
      valid_d   = valid_q;
      word_d    = word_q;

      if (pop) begin
         req_cnt_d = req_cnt_q + 1'b1;
      end

      case (state_q)
         ST_FILL: begin
            if (rd_pend_q) begin
               for (int i = 0; i < BYTES_PER_WORD; i++) begin
                  if (fill_q == CNT_WIDTH'(i)) begin
                     word_d[W-1-i*DATA_WIDTH -: DATA_WIDTH] = bus.fifo_data;
                  end
               end
               fill_d = fill_q + 1'b1;
               if (fill_q == LAST) begin
                  valid_d = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (timeout_hit) begin
               fill_d    = '0;
               req_cnt_d = '0;
               word_d    = '0;
            end
         end
         ST_HOLD: begin
            if (valid_q && bus.word_ready) begin
               valid_d   = 1'b0;
               fill_d    = '0;
               req_cnt_d = '0;
               state_d   = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // A pop issued during reset leaves rd_pend clear, so its data is never captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FILL;
         req_cnt_q <= '0;
         fill_q    <= '0;
         rd_pend_q <= 1'b0;
         valid_q   <= 1'b0;
         word_q    <= '0;
      end else begin
         state_q   <= state_d;
         req_cnt_q <= req_cnt_d;
         fill_q    <= fill_d;
         rd_pend_q <= rd_pend_d;
         valid_q   <= valid_d;
         word_q    <= word_d;
      end
   end

   assign bus.fifo_re    = pop;
   assign bus.word_data  = word_q;
   assign bus.word_valid = valid_q;
   assign bus.fill_level = fill_q;
   assign bus.drop_pulse = timeout_hit;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with BYTES_PER_WORD=4 and a small FIFO model.
// The timeout scenario checks drop behaviour when PACKER_TIMEOUT_EN is defined, retention otherwise.
module tb_fifo_word_packer;
   localparam int DW  = 8;
   localparam int BPW = 4;
   localparam int CW  = 3;
   localparam int TO  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_word_packer_if #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .CNT_WIDTH(CW)) bus ();

   fifo_word_packer #(
      .DATA_WIDTH    (DW),
      .BYTES_PER_WORD(BPW),
      .CNT_WIDTH     (CW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // FIFO model: pushes come from the tasks, pops happen on posedge when fifo_re is high.
   logic [7:0] fmem [0:255];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int overread = 0;

   assign bus.fifo_empty = (push_cnt == pop_cnt);

   always @(posedge clk) begin
      if (bus.fifo_re === 1'b1) begin
         if (push_cnt == pop_cnt) begin
            overread <= overread + 1;
         end else begin
            bus.fifo_data <= fmem[pop_cnt[7:0]];
            pop_cnt       <= pop_cnt + 1;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      fmem[push_cnt[7:0]] = b;
      push_cnt = push_cnt + 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.word_ready = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.fifo_re !== 1'b0) begin
         tests_failed++; $display("FAIL reset_fifo_re: got %b expected 0", bus.fifo_re);
      end
      tests_run++;
      if (bus.word_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_word_valid: got %b expected 0", bus.word_valid);
      end
      tests_run++;
      if (bus.word_data !== 32'h0) begin
         tests_failed++; $display("FAIL reset_word_data: got %h expected 00000000", bus.word_data);
      end
      tests_run++;
      if (bus.fill_level !== 3'd0 || bus.drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fill_drop: got fill=%0d drop=%b expected fill=0 drop=0", bus.fill_level, bus.drop_pulse);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] test_reset done");
   endtask

   task automatic test_stream();
      logic [6:0]  re_seq;
      logic [6:0]  v_seq;
      logic [31:0] w;
      logic [2:0]  fill_end;
      re_seq = '0; v_seq = '0; w = '0; fill_end = '0;
      bus.word_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'(8'h11 * (i + 1)));
      #1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         re_seq[k] = bus.fifo_re;
         v_seq[k]  = bus.word_valid;
         if (k == 5) w = bus.word_data;
         if (k == 6) fill_end = bus.fill_level;
      end
      tests_run++;
      if (re_seq !== 7'b0001111) begin
         tests_failed++; $display("FAIL stream_re_pattern: got %b expected 0001111", re_seq);
      end
      tests_run++;
      if (v_seq !== 7'b0100000) begin
         tests_failed++; $display("FAIL stream_valid_pattern: got %b expected 0100000", v_seq);
      end
      tests_run++;
      if (w !== 32'h11223344) begin
         tests_failed++; $display("FAIL stream_word: got %h expected 11223344", w);
      end
      tests_run++;
      if (fill_end !== 3'd0) begin
         tests_failed++; $display("FAIL stream_fill_after_hs: got %0d expected 0", fill_end);
      end
      $display("[TB] test_stream word=%h", w);
   endtask

   task automatic test_starved();
      bus.word_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(8'(8'hA0 + i));
         #1;
         tests_run++;
         if (bus.fifo_re !== 1'b1) begin
            tests_failed++; $display("FAIL starve_re_on[%0d]: got %b expected 1", i, bus.fifo_re);
         end
         @(negedge clk);
         @(negedge clk);
         tests_run++;
         if (bus.fill_level !== 3'(i + 1)) begin
            tests_failed++; $display("FAIL starve_fill[%0d]: got %0d expected %0d", i, bus.fill_level, i + 1);
         end
         if (i == 3) begin
            tests_run++;
            if (bus.word_valid !== 1'b1 || bus.word_data !== 32'hA0A1A2A3) begin
               tests_failed++;
               $display("FAIL starve_word: got valid=%b data=%h expected valid=1 data=a0a1a2a3", bus.word_valid, bus.word_data);
            end
         end
         for (int g = 0; g < 2; g++) begin
            tests_run++;
            if (bus.fifo_re !== 1'b0) begin
               tests_failed++; $display("FAIL starve_re_off[%0d]: got %b expected 0", i, bus.fifo_re);
            end
            @(negedge clk);
         end
      end
      tests_run++;
      if (bus.word_valid !== 1'b0 || overread !== 0) begin
         tests_failed++;
         $display("FAIL starve_end: got valid=%b overreads=%0d expected valid=0 overreads=0", bus.word_valid, overread);
      end
      $display("[TB] test_starved done");
   endtask

   task automatic test_backpressure();
      int n;
      int base;
      base = pop_cnt;
      bus.word_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(i + 1));
      n = 0;
      while (bus.word_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= 50) begin
         tests_failed++; $display("FAIL bp_first_valid: got timeout after %0d cycles expected valid", n);
      end
      for (int c = 0; c < 20; c++) begin
         tests_run++;
         if (bus.word_valid !== 1'b1 || bus.word_data !== 32'h01020304 || bus.fifo_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%h re=%b expected valid=1 data=01020304 re=0",
                     c, bus.word_valid, bus.word_data, bus.fifo_re);
         end
         @(negedge clk);
      end
      tests_run++;
      if (pop_cnt - base !== 4) begin
         tests_failed++; $display("FAIL bp_pop_count: got %0d expected 4", pop_cnt - base);
      end
      bus.word_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.word_valid !== 1'b0) begin
         tests_failed++; $display("FAIL bp_handshake: got valid=%b expected 0", bus.word_valid);
      end
      n = 0;
      while (bus.word_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= 50 || bus.word_data !== 32'h05060708) begin
         tests_failed++; $display("FAIL bp_second_word: got %h after %0d cycles expected 05060708", bus.word_data, n);
      end
      @(negedge clk);
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_reset_mid();
      int n;
      bus.word_ready = 1'b1;
      push(8'hB0);
      push(8'hB1);
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.fill_level !== 3'd2) begin
         tests_failed++; $display("FAIL rstmid_fill_before: got %0d expected 2", bus.fill_level);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (bus.fill_level !== 3'd0 || bus.word_data !== 32'h0 || bus.word_valid !== 1'b0 ||
          bus.fifo_re !== 1'b0 || bus.drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_outputs: got fill=%0d data=%h valid=%b re=%b drop=%b expected all zero",
                  bus.fill_level, bus.word_data, bus.word_valid, bus.fifo_re, bus.drop_pulse);
      end
      for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
      n = 0;
      while (bus.word_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= 50 || bus.word_data !== 32'hC0C1C2C3) begin
         tests_failed++; $display("FAIL rstmid_word: got %h after %0d cycles expected c0c1c2c3", bus.word_data, n);
      end
      @(negedge clk);
      $display("[TB] test_reset_mid done");
   endtask

   task automatic test_timeout();
      int n;
      int drops;
      bus.word_ready = 1'b1;
      push(8'hD0);
      push(8'hD1);
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.fill_level !== 3'd2) begin
         tests_failed++; $display("FAIL to_fill_before: got %0d expected 2", bus.fill_level);
      end
      drops = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.drop_pulse === 1'b1) drops++;
         @(negedge clk);
      end
`ifdef PACKER_TIMEOUT_EN
      tests_run++;
      if (drops !== 1) begin
         tests_failed++; $display("FAIL to_drop_count: got %0d expected 1", drops);
      end
      tests_run++;
      if (bus.fill_level !== 3'd0 || bus.word_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL to_discard: got fill=%0d data=%h expected fill=0 data=00000000", bus.fill_level, bus.word_data);
      end
      for (int i = 0; i < 4; i++) push(8'(8'hE0 + i));
      n = 0;
      while (bus.word_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= 50 || bus.word_data !== 32'hE0E1E2E3) begin
         tests_failed++; $display("FAIL to_clean_word: got %h after %0d cycles expected e0e1e2e3", bus.word_data, n);
      end
`else
      tests_run++;
      if (drops !== 0) begin
         tests_failed++; $display("FAIL to_no_drop: got %0d drops expected 0", drops);
      end
      tests_run++;
      if (bus.fill_level !== 3'd2 || bus.word_data[31:16] !== 16'hD0D1) begin
         tests_failed++;
         $display("FAIL to_retained: got fill=%0d top=%h expected fill=2 top=d0d1", bus.fill_level, bus.word_data[31:16]);
      end
      push(8'hD2);
      push(8'hD3);
      n = 0;
      while (bus.word_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= 50 || bus.word_data !== 32'hD0D1D2D3) begin
         tests_failed++; $display("FAIL to_resumed_word: got %h after %0d cycles expected d0d1d2d3", bus.word_data, n);
      end
`endif
      @(negedge clk);
      tests_run++;
      if (overread !== 0) begin
         tests_failed++; $display("FAIL overread_total: got %0d expected 0", overread);
      end
      $display("[TB] test_timeout done");
   endtask

   initial begin
      bus.word_ready = 1'b0;
      test_reset();
      test_stream();
      test_starved();
      test_backpressure();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
